// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt priority arbiter: FSM encodings and
// default sizing of the interrupt line set.
package intr_pkg;

  localparam int NUM_INTR_DEF = 16;
  localparam int PRIO_W_DEF   = 4;

  typedef enum logic [2:0] {
    S_NOINTR   = 3'b000,
    S_INTR_ACT = 3'b001,
    S_WAITING  = 3'b010
  } state_e;

endpackage

// File: rtl/intr_prio_sel.sv
// Combinational winner selection: highest priority among eligible lines,
// with lower indices winning ties.
module intr_prio_sel #(
  parameter int NUM_INTR = 16,
  parameter int PRIO_W   = 4,
  parameter int WIDTH    = $clog2(NUM_INTR)
) (
  input  logic [NUM_INTR*PRIO_W-1:0] prio_flat,
  input  logic [NUM_INTR-1:0]        eligible,
  output logic                       any_eligible,
  output logic [WIDTH-1:0]           winner
);

  logic [PRIO_W-1:0] best_prio;

  // Strict '>' keeps the first (lowest-index) line among equal priorities.
  // Eligible lines never have priority 0, so the first one always beats the seed.
  always_comb begin
    best_prio    = '0;
    winner       = '0;
    any_eligible = 1'b0;
    for (int k = 0; k < NUM_INTR; k++) begin
      if (eligible[k] && (prio_flat[k*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio    = prio_flat[k*PRIO_W +: PRIO_W];
        winner       = WIDTH'(k);
        any_eligible = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_prio_arbiter.sv
// Interrupt service sequencer: sticky pending capture, priority selection,
// valid/serviced handshake and a post-service hold-off window.
module intr_prio_arbiter
  import intr_pkg::*;
#(
  parameter int NUM_INTR = NUM_INTR_DEF,
  parameter int WIDTH    = $clog2(NUM_INTR),
  parameter int PRIO_W   = PRIO_W_DEF,
  parameter int HOLDOFF  = 2
) (
  input  logic                       pclk_i,
  input  logic                       prst_i,
  input  logic [NUM_INTR*PRIO_W-1:0] prio_flat_i,
  input  logic [NUM_INTR-1:0]        intr_active_i,
  input  logic                       intr_serviced_i,
  output logic [WIDTH-1:0]           intr_to_service_o,
  output logic                       intr_valid_o,
  output logic [NUM_INTR-1:0]        pending_o
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_INTR-1:0] pending_q, eligible, clr;
  logic [WIDTH-1:0]    winner, idx_d;
  logic                any_eligible, valid_d;

  // A priority of zero masks a line without dropping its pending bit.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_INTR; k++) begin
      eligible[k] = pending_q[k] && (prio_flat_i[k*PRIO_W +: PRIO_W] != '0);
    end
  end

  intr_prio_sel #(
    .NUM_INTR (NUM_INTR),
    .PRIO_W   (PRIO_W),
    .WIDTH    (WIDTH)
  ) u_sel (
    .prio_flat    (prio_flat_i),
    .eligible     (eligible),
    .any_eligible (any_eligible),
    .winner       (winner)
  );

  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      state_q           <= S_NOINTR;
      cnt_q             <= '0;
      pending_q         <= '0;
      intr_to_service_o <= '0;
      intr_valid_o      <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      pending_q         <= (pending_q | intr_active_i) & ~clr;
      intr_to_service_o <= idx_d;
      intr_valid_o      <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NOINTR:   if (any_eligible)    state_d = S_INTR_ACT;
      S_INTR_ACT: if (intr_serviced_i) state_d = S_WAITING;
      S_WAITING:  if (cnt_q == '0)     state_d = S_NOINTR;
      default:                         state_d = S_NOINTR;
    endcase
  end

  // The presented index is held (not cleared) once serviced.
  always_comb begin
    idx_d   = intr_to_service_o;
    valid_d = intr_valid_o;
    cnt_d   = cnt_q;
    clr     = '0;
    case (state_q)
      S_NOINTR: begin
        if (any_eligible) begin
          idx_d   = winner;
          valid_d = 1'b1;
        end
      end
      S_INTR_ACT: begin
        if (intr_serviced_i) begin
          valid_d                = 1'b0;
          clr[intr_to_service_o] = 1'b1;
          cnt_d                  = CNT_W'(HOLDOFF - 1);
        end
      end
      S_WAITING: begin
        valid_d = 1'b0;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      default: valid_d = 1'b0;
    endcase
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_intr_prio_arbiter.sv
// Self-checking bench for intr_prio_arbiter: directed scenarios followed by
// randomized traffic, all checked against an edge-level behavioural model.
module tb_intr_prio_arbiter;

  localparam int N       = 16;
  localparam int PW      = 4;
  localparam int W       = 4;
  localparam int HOLDOFF = 2;

  logic          pclk_i = 1'b0;
  logic          prst_i;
  logic [N*PW-1:0] prio_flat_i;
  logic [N-1:0]  intr_active_i;
  logic          intr_serviced_i;
  logic [W-1:0]  intr_to_service_o;
  logic          intr_valid_o;
  logic [N-1:0]  pending_o;

  logic [PW-1:0] prio [N];

  int compared   = 0;
  int mismatched = 0;

  // Model: pending set, whether a line is presented, which one, and the
  // earliest edge number at which a new presentation may happen.
  bit [N-1:0] m_pending;
  bit         m_present;
  int         m_cur;
  int         m_ready;
  int         m_edge;

  intr_prio_arbiter #(
    .NUM_INTR (N),
    .WIDTH    (W),
    .PRIO_W   (PW),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .prio_flat_i       (prio_flat_i),
    .intr_active_i     (intr_active_i),
    .intr_serviced_i   (intr_serviced_i),
    .intr_to_service_o (intr_to_service_o),
    .intr_valid_o      (intr_valid_o),
    .pending_o         (pending_o)
  );

  always #5 pclk_i = ~pclk_i;

  always_comb begin
    prio_flat_i = '0;
    for (int k = 0; k < N; k++) prio_flat_i[k*PW +: PW] = prio[k];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelEdge();
    bit [N-1:0] next_pending;
    int best;
    if (!prst_i) begin
      m_pending = '0;
      m_present = 1'b0;
      m_cur     = 0;
      m_ready   = m_edge + 1;
    end else begin
      next_pending = m_pending | intr_active_i;
      if (m_present && intr_serviced_i) begin
        next_pending[m_cur] = 1'b0;
        m_present = 1'b0;
        m_ready   = m_edge + HOLDOFF + 1;
      end else if (!m_present && m_edge >= m_ready) begin
        best = -1;
        for (int k = 0; k < N; k++) begin
          if (m_pending[k] && prio[k] != 0 && (best < 0 || prio[k] > prio[best])) best = k;
        end
        if (best >= 0) begin
          m_present = 1'b1;
          m_cur     = best;
        end
      end
      m_pending = next_pending;
    end
    m_edge++;
  endtask

  task automatic checkOutput(input string tag);
    compared++;
    assert (intr_valid_o === m_present) else begin
      mismatched++;
      $error("[TB] FAIL %s valid: observed %b expected %b", tag, intr_valid_o, m_present);
    end
    compared++;
    assert (intr_to_service_o === W'(m_cur)) else begin
      mismatched++;
      $error("[TB] FAIL %s index: observed %0d expected %0d", tag, intr_to_service_o, m_cur);
    end
    compared++;
    assert (pending_o === m_pending) else begin
      mismatched++;
      $error("[TB] FAIL %s pending: observed %h expected %h", tag, pending_o, m_pending);
    end
  endtask

  task automatic applyStimulus(input string tag);
    modelEdge();
    @(posedge pclk_i);
    #1;
    checkOutput(tag);
  endtask

  task automatic waitValid(input string tag, input int budget, output int n);
    n = 0;
    while (intr_valid_o !== 1'b1 && n < budget) begin
      applyStimulus(tag);
      n++;
    end
    compared++;
    assert (intr_valid_o === 1'b1) else begin
      mismatched++;
      $error("[TB] FAIL %s wait: observed valid %b expected 1 within %0d edges", tag, intr_valid_o, budget);
    end
  endtask

  task automatic expectIndex(input string tag, input int exp_idx);
    compared++;
    assert (intr_valid_o === 1'b1 && intr_to_service_o === W'(exp_idx)) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed valid %b index %0d expected valid 1 index %0d",
             tag, intr_valid_o, intr_to_service_o, exp_idx);
    end
  endtask

  initial begin
    int n;
    prst_i          = 1'b0;
    intr_active_i   = '0;
    intr_serviced_i = 1'b0;
    for (int k = 0; k < N; k++) prio[k] = '0;
    m_pending = '0; m_present = 1'b0; m_cur = 0; m_ready = 0; m_edge = 0;

    // Reset holds everything quiet even with all lines requesting.
    intr_active_i = 16'hFFFF;
    repeat (3) applyStimulus("reset");
    intr_active_i = '0;
    prst_i = 1'b1;
    applyStimulus("release");

    // Single line pulse, two-edge latency, then service clears pending.
    prio[5] = 4'd3;
    intr_active_i[5] = 1'b1;
    applyStimulus("single_e0");
    intr_active_i[5] = 1'b0;
    applyStimulus("single_e1");
    expectIndex("single_idx", 5);
    intr_serviced_i = 1'b1;
    applyStimulus("single_svc");
    intr_serviced_i = 1'b0;
    compared++;
    assert (pending_o[5] === 1'b0) else begin
      mismatched++;
      $error("[TB] FAIL single_clr: observed %b expected 0", pending_o[5]);
    end

    // Tie between 2 and 9 resolved by index, 12 last; each held until serviced.
    prio[2] = 4'd7; prio[9] = 4'd7; prio[12] = 4'd4;
    intr_active_i = 16'h1204;
    waitValid("tie_a", 10, n);
    expectIndex("tie_first", 2);
    intr_serviced_i = 1'b1; intr_active_i[2] = 1'b0;
    applyStimulus("tie_svc2");
    intr_serviced_i = 1'b0;
    waitValid("tie_b", 10, n);
    expectIndex("tie_second", 9);
    intr_serviced_i = 1'b1; intr_active_i[9] = 1'b0;
    applyStimulus("tie_svc9");
    intr_serviced_i = 1'b0;
    waitValid("tie_c", 10, n);
    expectIndex("tie_third", 12);
    intr_serviced_i = 1'b1; intr_active_i[12] = 1'b0;
    applyStimulus("tie_svc12");
    intr_serviced_i = 1'b0;
    repeat (HOLDOFF + 1) applyStimulus("tie_idle");

    // Masked line stays pending and is presented once unmasked.
    prio[3] = 4'd0;
    intr_active_i[3] = 1'b1;
    applyStimulus("mask_set");
    intr_active_i[3] = 1'b0;
    repeat (4) applyStimulus("mask_hold");
    compared++;
    assert (pending_o[3] === 1'b1 && intr_valid_o === 1'b0) else begin
      mismatched++;
      $error("[TB] FAIL mask: observed pending %b valid %b expected 1/0", pending_o[3], intr_valid_o);
    end
    prio[3] = 4'd1;
    waitValid("unmask", 5, n);
    expectIndex("unmask_idx", 3);
    intr_serviced_i = 1'b1;
    applyStimulus("unmask_svc");
    intr_serviced_i = 1'b0;
    repeat (HOLDOFF + 1) applyStimulus("unmask_idle");

    // No pre-emption; serviced during hold-off is ignored; hold-off length.
    prio[4] = 4'd1; prio[8] = 4'd15;
    intr_active_i[4] = 1'b1;
    waitValid("prem_a", 5, n);
    intr_active_i[4] = 1'b0;
    intr_active_i[8] = 1'b1;
    repeat (3) applyStimulus("prem_hold");
    expectIndex("prem_stay", 4);
    intr_serviced_i = 1'b1;
    intr_active_i[8] = 1'b0;
    applyStimulus("prem_svc");
    waitValid("prem_b", 10, n);
    intr_serviced_i = 1'b0;
    compared++;
    assert (n == HOLDOFF + 1) else begin
      mismatched++;
      $error("[TB] FAIL holdoff_len: observed %0d edges expected %0d", n, HOLDOFF + 1);
    end
    expectIndex("prem_next", 8);

    // Reset while presenting; line still high comes back after release.
    intr_active_i[8] = 1'b1;
    prst_i = 1'b0;
    applyStimulus("mid_reset");
    compared++;
    assert (intr_valid_o === 1'b0 && pending_o === '0) else begin
      mismatched++;
      $error("[TB] FAIL mid_reset: observed valid %b pending %h expected 0/0", intr_valid_o, pending_o);
    end
    prst_i = 1'b1;
    waitValid("re_present", 5, n);
    expectIndex("re_idx", 8);
    intr_serviced_i = 1'b1; intr_active_i[8] = 1'b0;
    applyStimulus("re_svc");
    intr_serviced_i = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      prst_i          = ($urandom_range(0, 79) != 0);
      intr_active_i   = 16'($urandom) & 16'($urandom) & 16'($urandom);
      intr_serviced_i = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) prio[$urandom_range(0, N - 1)] = 4'($urandom);
      applyStimulus("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
